// File: rtl/cpu_arb_pkg.sv
// Shared types and constants for the CPU / UART-programmer memory port arbiter.
package cpu_arb_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    UPG     = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  // Programmer address bit that picks dmem over imem; equals the default ADDR_W.
  localparam int MEM_SEL_BIT = 14;
  localparam int WCOUNT_W    = 16;
  localparam int REL_CNT_W   = 8;

endpackage

// File: rtl/mem_port_arbiter_rise_detect.sv
// Registered rising-edge detector; the previous-value register clears on reset.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev <= 1'b0;
    else      prev <= d;
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/mem_port_arbiter.sv
// Hands the imem/dmem write ports to the UART programmer while the CPU is held
// in reset, and gives dmem back to the CPU after a fixed reset-hold period.
module mem_port_arbiter
  import cpu_arb_pkg::*;
#(
  parameter int ADDR_W         = MEM_SEL_BIT,
  parameter int DATA_W         = 32,
  parameter int RELEASE_CYCLES = 4            // legal range 1..255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                upg_req_i,
  input  logic                upg_wen_i,
  input  logic [ADDR_W:0]     upg_adr_i,
  input  logic [DATA_W-1:0]   upg_dat_i,
  input  logic                upg_done_i,
  input  logic                cpu_wen_i,
  input  logic [ADDR_W-1:0]   cpu_adr_i,
  input  logic [DATA_W-1:0]   cpu_dat_i,
  output logic                cpu_hold_o,
  output logic                cpu_rst_n_o,
  output logic                imem_wen_o,
  output logic [ADDR_W-1:0]   imem_adr_o,
  output logic [DATA_W-1:0]   imem_dat_o,
  output logic                dmem_wen_o,
  output logic [ADDR_W-1:0]   dmem_adr_o,
  output logic [DATA_W-1:0]   dmem_dat_o,
  output logic                upg_busy_o,
  output logic                upg_abort_o,
  output logic [WCOUNT_W-1:0] upg_wcount_o
);

  localparam logic [REL_CNT_W-1:0] REL_LOAD = REL_CNT_W'(RELEASE_CYCLES - 1);

  arb_state_e           state;
  logic                 req_rise;
  logic                 alive;
  logic [REL_CNT_W-1:0] rel_cnt;
  logic [WCOUNT_W-1:0]  wcount;
  logic                 abort;
  logic                 sel_dmem;

  assign sel_dmem = upg_adr_i[ADDR_W];

  rise_detect u_req_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (upg_req_i),
    .rise (req_rise)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      alive   <= 1'b0;
      rel_cnt <= '0;
      wcount  <= '0;
      abort   <= 1'b0;
    end else begin
      alive <= 1'b1;
      case (state)
        RUN: begin
          if (req_rise) begin
            state  <= DRAIN;
            wcount <= '0;
            abort  <= 1'b0;
          end
        end
        DRAIN: state <= UPG;
        UPG: begin
          // A write in the same cycle as done still counts.
          if (upg_wen_i && (wcount != '1)) wcount <= wcount + WCOUNT_W'(1);
          if (upg_done_i || !upg_req_i) begin
            state   <= RELEASE;
            rel_cnt <= REL_LOAD;
            if (!upg_done_i) abort <= 1'b1;
          end
        end
        RELEASE: begin
          if (rel_cnt == '0) state <= RUN;
          else               rel_cnt <= rel_cnt - REL_CNT_W'(1);
        end
        default: state <= RUN;
      endcase
    end
  end

  // alive gates CPU stores so nothing reaches dmem while reset is applied.
  always_comb begin
    imem_wen_o = 1'b0;
    imem_adr_o = upg_adr_i[ADDR_W-1:0];
    imem_dat_o = upg_dat_i;
    dmem_wen_o = 1'b0;
    dmem_adr_o = cpu_adr_i;
    dmem_dat_o = cpu_dat_i;
    case (state)
      RUN: dmem_wen_o = alive & cpu_wen_i;
      UPG: begin
        imem_wen_o = upg_wen_i & ~sel_dmem;
        dmem_wen_o = upg_wen_i & sel_dmem;
        dmem_adr_o = upg_adr_i[ADDR_W-1:0];
        dmem_dat_o = upg_dat_i;
      end
      default: ;
    endcase
  end

  assign upg_busy_o   = (state != RUN);
  assign cpu_hold_o   = upg_busy_o;
  assign cpu_rst_n_o  = alive & ((state == RUN) || (state == DRAIN));
  assign upg_abort_o  = abort;
  assign upg_wcount_o = wcount;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; memory writes are checked against a queue.
module tb_mem_port_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;

  typedef struct packed {
    logic          dmem;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } wr_t;

  logic          clk, rst;
  logic          upg_req_i, upg_wen_i, upg_done_i, cpu_wen_i;
  logic [AW:0]   upg_adr_i;
  logic [DW-1:0] upg_dat_i, cpu_dat_i;
  logic [AW-1:0] cpu_adr_i;
  logic          cpu_hold_o, cpu_rst_n_o, imem_wen_o, dmem_wen_o;
  logic          upg_busy_o, upg_abort_o;
  logic [AW-1:0] imem_adr_o, dmem_adr_o;
  logic [DW-1:0] imem_dat_o, dmem_dat_o;
  logic [15:0]   upg_wcount_o;

  int  n_checks = 0;
  int  n_fail   = 0;
  wr_t sb[$];

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RELEASE_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .upg_req_i(upg_req_i), .upg_wen_i(upg_wen_i), .upg_adr_i(upg_adr_i),
    .upg_dat_i(upg_dat_i), .upg_done_i(upg_done_i),
    .cpu_wen_i(cpu_wen_i), .cpu_adr_i(cpu_adr_i), .cpu_dat_i(cpu_dat_i),
    .cpu_hold_o(cpu_hold_o), .cpu_rst_n_o(cpu_rst_n_o),
    .imem_wen_o(imem_wen_o), .imem_adr_o(imem_adr_o), .imem_dat_o(imem_dat_o),
    .dmem_wen_o(dmem_wen_o), .dmem_adr_o(dmem_adr_o), .dmem_dat_o(dmem_dat_o),
    .upg_busy_o(upg_busy_o), .upg_abort_o(upg_abort_o), .upg_wcount_o(upg_wcount_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every memory write seen mid-cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    if (imem_wen_o || dmem_wen_o) begin
      wr_t exp, obs;
      chk("both_wen", {imem_wen_o, dmem_wen_o} == 2'b11, 0);
      obs.dmem = dmem_wen_o;
      obs.adr  = dmem_wen_o ? dmem_adr_o : imem_adr_o;
      obs.dat  = dmem_wen_o ? dmem_dat_o : imem_dat_o;
      chk("unexpected_write", sb.size() == 0, 0);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        chk("mem_write", obs, exp);
      end
    end
  end

  initial begin
    rst = 1'b1;
    upg_req_i = 0; upg_wen_i = 0; upg_done_i = 0; upg_adr_i = '0; upg_dat_i = '0;
    cpu_wen_i = 0; cpu_adr_i = '0; cpu_dat_i = '0;
    #1 rst = 1'b0;
    #1 cpu_wen_i = 1'b1;
    #1;
    chk("rst_cpu_rst_n", cpu_rst_n_o, 0);
    chk("rst_hold", cpu_hold_o, 0);
    chk("rst_wens", {imem_wen_o, dmem_wen_o}, 0);
    chk("rst_busy_abort", {upg_busy_o, upg_abort_o}, 0);
    chk("rst_wcount", upg_wcount_o, 0);
    cpu_wen_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rst_n_before_edge", cpu_rst_n_o, 0);
    tick();
    chk("rst_n_after_edge", cpu_rst_n_o, 1);
    chk("hold_run", cpu_hold_o, 0);
    repeat (3) tick();
    chk("idle_wcount", upg_wcount_o, 0);
    chk("idle_wens", {imem_wen_o, dmem_wen_o}, 0);
    chk("idle_busy", upg_busy_o, 0);

    // CPU store in RUN
    cpu_wen_i = 1; cpu_adr_i = 14'h0010; cpu_dat_i = 32'hDEADBEEF;
    sb.push_back('{1'b1, 14'h0010, 32'hDEADBEEF});
    tick();
    // request rise together with a CPU store: store still lands
    upg_req_i = 1; cpu_adr_i = 14'h0020; cpu_dat_i = 32'hCAFE0001;
    sb.push_back('{1'b1, 14'h0020, 32'hCAFE0001});
    tick();
    cpu_wen_i = 0;
    chk("drain_busy", upg_busy_o, 1);
    chk("drain_hold", cpu_hold_o, 1);
    chk("drain_wcount", upg_wcount_o, 0);
    upg_wen_i = 1; upg_adr_i = 15'h0077; upg_dat_i = 32'h0BADF00D;  // ignored in DRAIN
    tick();
    chk("upg_cpu_rst_n", cpu_rst_n_o, 0);
    upg_adr_i = 15'h0004; upg_dat_i = 32'h00000013;
    sb.push_back('{1'b0, 14'h0004, 32'h00000013});
    tick();
    chk("wcount_1", upg_wcount_o, 1);
    upg_adr_i = 15'h4008; upg_dat_i = 32'h12345678;
    sb.push_back('{1'b1, 14'h0008, 32'h12345678});
    tick();
    upg_wen_i = 0; upg_done_i = 1;
    chk("wcount_2", upg_wcount_o, 2);
    tick();
    upg_done_i = 0;  // request stays high through the return to RUN
    for (int i = 0; i < 4; i++) begin
      chk("release_rst_n", cpu_rst_n_o, 0);
      chk("release_busy", upg_busy_o, 1);
      tick();
    end
    chk("run_rst_n", cpu_rst_n_o, 1);
    chk("run_hold", cpu_hold_o, 0);
    chk("run_busy", upg_busy_o, 0);
    chk("run_wcount", upg_wcount_o, 2);
    chk("run_abort", upg_abort_o, 0);
    repeat (2) tick();
    chk("no_retrigger", upg_busy_o, 0);
    upg_req_i = 0;
    tick();

    // write and done in the same cycle
    upg_req_i = 1;
    repeat (2) tick();
    upg_wen_i = 1; upg_done_i = 1; upg_adr_i = 15'h0001; upg_dat_i = 32'hAAAA5555;
    sb.push_back('{1'b0, 14'h0001, 32'hAAAA5555});
    tick();
    upg_wen_i = 0; upg_done_i = 0; upg_req_i = 0;
    chk("wd_wcount", upg_wcount_o, 1);
    chk("wd_release", {upg_busy_o, cpu_rst_n_o}, 2'b10);
    chk("wd_abort", upg_abort_o, 0);
    repeat (4) tick();
    chk("wd_run", upg_busy_o, 0);

    // request drop mid-UPG
    upg_req_i = 1;
    repeat (2) tick();
    upg_wen_i = 1; upg_adr_i = 15'h4003; upg_dat_i = 32'h00000077;
    sb.push_back('{1'b1, 14'h0003, 32'h00000077});
    tick();
    upg_wen_i = 0; upg_req_i = 0;
    tick();
    chk("abort_set", upg_abort_o, 1);
    chk("abort_busy", upg_busy_o, 1);
    repeat (4) tick();
    chk("abort_sticky", upg_abort_o, 1);
    chk("abort_run", upg_busy_o, 0);
    upg_req_i = 1;
    tick();
    chk("abort_cleared", upg_abort_o, 0);
    chk("abort_wcount_cleared", upg_wcount_o, 0);
    tick();

    // reset during a UPG write
    upg_wen_i = 1; upg_adr_i = 15'h0002; upg_dat_i = 32'h00000099;
    #1 chk("upg_write_visible", imem_wen_o, 1);
    rst = 1'b0;
    #1;
    chk("midrst_wens", {imem_wen_o, dmem_wen_o}, 0);
    chk("midrst_rst_n", cpu_rst_n_o, 0);
    chk("midrst_busy", upg_busy_o, 0);
    chk("midrst_wcount", upg_wcount_o, 0);
    chk("midrst_hold", cpu_hold_o, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
